slave_out_tx: RTL and testbench
===============================

Name: slave_out_tx

Overview:
- Slave-side serial transmitter that drives the bit-serial read-data path consumed by the master receive stage.
- Pops parallel words from the slave's local data source (memory/FIFO read port).
- Serialises each word LSB first, one bit per cycle, qualified by slave_valid and stalled by master_ready.
- Sends a burst of burst_num+1 words while the arbiter grant holds.

Parameters:
DATA_LEN, 8, width of one data word in bits
BURST_LEN, 12, width of the burst-count field

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse: read transaction addressed to this slave, begin sending
burst_num  input  BURST_LEN  additional words after the first; captured on start
approval_grant  input  1  arbiter grant; low aborts the transfer
master_ready  input  1  master can accept the current bit this cycle
word_in  input  DATA_LEN  next word from the local data source
word_valid  input  1  word_in holds a valid word
word_ack  output  1  pop strobe to the data source (combinational)
slave_valid  output  1  tx_data carries a valid bit
tx_data  output  1  serial data bit, LSB of word first
tx_busy  output  1  a transaction is in progress (state != IDLE)
tx_done  output  1  one-cycle pulse: full burst sent
tx_abort  output  1  one-cycle pulse: transfer cut short by loss of grant

Behaviour:
- Reset: state=IDLE. Shift register, bit counter and words_left are 0. All outputs are 0.
- State IDLE:
  - On start=1, capture words_left<=burst_num and go to WAIT_WORD.
  - start is ignored in every other state.
- State WAIT_WORD:
  - approval_grant=0: go to IDLE and pulse tx_abort.
  - Else if word_valid=1: word_ack=1 this cycle, shift<=word_in, bit_cnt<=0, go to SEND.
  - Else hold.
- State SEND:
  - slave_valid=1 and tx_data=shift[0], both direct from registers.
  - approval_grant=0 has priority: go to IDLE, pulse tx_abort, drop slave_valid next cycle.
  - master_ready=0: hold bit and counter (stall, no bit lost).
  - master_ready=1 and bit_cnt<last: shift right, bit_cnt+1.
  - master_ready=1 and bit_cnt==last, with words_left==0: go to DONE.
  - master_ready=1 and bit_cnt==last, with words_left!=0: words_left-1. If word_valid=1, word_ack=1, load word_in and stay in SEND (back-to-back, no gap cycle). Else go to WAIT_WORD.
  - last = DATA_LEN-1.
- State DONE: tx_done=1 for one cycle, then go to IDLE.
- Latency:
  - start in cycle 0 gives WAIT_WORD in cycle 1.
  - With word_valid high, word_ack is in cycle 1 and the first bit is valid in cycle 2.
  - With master_ready and word_valid constantly high, SEND lasts (burst_num+1)*DATA_LEN cycles, followed by one DONE cycle.
- Width and wrap rules:
  - words_left is BURST_LEN bits and only counts down, so burst_num=all-ones sends 2^BURST_LEN words with no wrap.
  - bit_cnt is clog2(DATA_LEN+1) bits.
- word_ack is only ever asserted when word_valid=1 and approval_grant=1; at most one pop per word.
- Reset mid-transfer returns to IDLE immediately, with no tx_done or tx_abort pulse. The partially sent word is discarded.

Optional Feature:
- Macro SLAVE_TX_PARITY_EN.
- When defined: after the last data bit of each word, one extra even-parity bit (XOR of the word) is sent with slave_valid=1, under the same stall rules. last becomes DATA_LEN, and each word takes DATA_LEN+1 bit-cycles.
- When undefined: no parity bit, last=DATA_LEN-1.

Decomposition:
- Shared package bus_pkg holds:
  - state encodings TX_IDLE, TX_WAIT_WORD, TX_SEND, TX_DONE (2-bit);
  - the default DATA_LEN/BURST_LEN constants;
  - the read-instruction code 2'b11 used to generate start.
- One natural sub-module: tx_shift_reg, the parallel-load, right-shift PISO. Inputs: load, shift_en, word_in. Output: bit0. Optional parity append.

Test Plan:
1. Single word: burst_num=0, word_in=8'hA5, master_ready=1 -> tx_data 1,0,1,0,0,1,0,1 in cycles 2-9 with slave_valid=1; tx_done in cycle 10; word_ack once, in cycle 1.
2. Burst: burst_num=2, words 8'h01, 8'hFF, 8'h3C, word_valid always 1 -> 24 contiguous valid bits; word_ack in cycles 1, 9, 17; tx_done in cycle 26.
3. Stall: master_ready low for 3 cycles during bit 4 of 8'hA5 -> bit 4 held for 3 cycles; completion slips by 3 cycles; serial stream unchanged.
4. Source gap: burst_num=1, word_valid low for 4 cycles after word 0 -> WAIT_WORD for 4 cycles with slave_valid=0, then word 1 sent intact and tx_done.
5. Grant loss and reset: approval_grant dropped at bit 3 -> tx_abort pulse, IDLE next cycle, no tx_done. Separately, reset asserted mid-SEND -> all outputs 0 asynchronously, and a new start then works normally.
6. With SLAVE_TX_PARITY_EN: 8'hA5 -> 8 data bits plus parity bit 0; 8'h07 -> parity bit 1; tx_done in cycle 11.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the slave transmit path: state encodings,
// default widths, the read-instruction code and the parity switch.
// Optional feature macro: SLAVE_TX_PARITY_EN (appends one even-parity bit per word).
package bus_pkg;

  localparam int DATA_LEN_DEF  = 8;
  localparam int BURST_LEN_DEF = 12;

  // Instruction code that the decoder turns into a start pulse for this slave.
  localparam logic [1:0] RD_INSTR = 2'b11;

`ifdef SLAVE_TX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  typedef enum logic [1:0] {
    TX_IDLE      = 2'd0,
    TX_WAIT_WORD = 2'd1,
    TX_SEND      = 2'd2,
    TX_DONE      = 2'd3
  } tx_state_t;

endpackage

// File: rtl/tx_shift_reg.sv
// Parallel-load, right-shift PISO. bit0 is the bit currently on the wire.
// With SLAVE_TX_PARITY_EN the even parity of the word sits above the MSB,
// so it falls out after the last data bit.
module tx_shift_reg
  import bus_pkg::*;
#(
  parameter int DATA_LEN = DATA_LEN_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                shift_en,
  input  logic [DATA_LEN-1:0] word_in,
  output logic                bit0
);

  localparam int W = DATA_LEN + PAR_BITS;

  logic [W-1:0] load_word;
  logic [W-1:0] shift_reg;
  logic [W-1:0] shift_next;

`ifdef SLAVE_TX_PARITY_EN
  assign load_word = {^word_in, word_in};
`else
  assign load_word = word_in;
`endif

  // Per-bit next value: load wins over shift; the top bit refills with 0.
  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_bit
      if (gi == W - 1) begin : g_top
        assign shift_next[gi] = load ? load_word[gi] : (shift_en ? 1'b0 : shift_reg[gi]);
      end else begin : g_mid
        assign shift_next[gi] = load ? load_word[gi] : (shift_en ? shift_reg[gi+1] : shift_reg[gi]);
      end
    end
  endgenerate

  // Shift register state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) shift_reg <= '0;
    else       shift_reg <= shift_next;
  end

  assign bit0 = shift_reg[0];

endmodule

// File: rtl/slave_out_tx.sv
// Slave-side bit-serial transmitter: pops words from the local source and
// sends them LSB first, one bit per accepted cycle, for burst_num+1 words
// while the arbiter grant holds.
// Optional feature macro: SLAVE_TX_PARITY_EN (one extra even-parity bit per word).
module slave_out_tx
  import bus_pkg::*;
#(
  parameter int DATA_LEN  = DATA_LEN_DEF,
  parameter int BURST_LEN = BURST_LEN_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [BURST_LEN-1:0] burst_num,
  input  logic                 approval_grant,
  input  logic                 master_ready,
  input  logic [DATA_LEN-1:0]  word_in,
  input  logic                 word_valid,
  output logic                 word_ack,
  output logic                 slave_valid,
  output logic                 tx_data,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 tx_abort
);

  localparam int CNT_W = $clog2(DATA_LEN + 1);
  // Index of the final bit-cycle of a word (parity bit included when enabled).
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_LEN - 1 + PAR_BITS);

  tx_state_t            state_reg, state_next;
  logic [CNT_W-1:0]     bit_cnt_reg, bit_cnt_next;
  logic [BURST_LEN-1:0] words_left_reg, words_left_next;
  logic                 load, shift_en, bit0;

  tx_shift_reg #(.DATA_LEN(DATA_LEN)) u_shift (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .shift_en (shift_en),
    .word_in  (word_in),
    .bit0     (bit0)
  );

  // State, bit counter and remaining-word count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= TX_IDLE;
      bit_cnt_reg    <= '0;
      words_left_reg <= '0;
    end else begin
      state_reg      <= state_next;
      bit_cnt_reg    <= bit_cnt_next;
      words_left_reg <= words_left_next;
    end
  end

  // Next-state logic plus the pop strobe and abort pulse.
  always_comb begin
    state_next      = state_reg;
    bit_cnt_next    = bit_cnt_reg;
    words_left_next = words_left_reg;
    load            = 1'b0;
    shift_en        = 1'b0;
    word_ack        = 1'b0;
    tx_abort        = 1'b0;
    case (state_reg)
      TX_IDLE: begin
        if (start) begin
          words_left_next = burst_num;
          state_next      = TX_WAIT_WORD;
        end
      end
      TX_WAIT_WORD: begin
        if (!approval_grant) begin
          tx_abort   = 1'b1;
          state_next = TX_IDLE;
        end else if (word_valid) begin
          word_ack     = 1'b1;
          load         = 1'b1;
          bit_cnt_next = '0;
          state_next   = TX_SEND;
        end
      end
      TX_SEND: begin
        if (!approval_grant) begin
          tx_abort   = 1'b1;
          state_next = TX_IDLE;
        end else if (master_ready) begin
          if (bit_cnt_reg < LAST_CNT) begin
            shift_en     = 1'b1;
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end else if (words_left_reg == '0) begin
            state_next = TX_DONE;
          end else begin
            // Down-count only, so an all-ones burst_num never wraps early.
            words_left_next = words_left_reg - 1'b1;
            if (word_valid) begin
              word_ack     = 1'b1;
              load         = 1'b1;
              bit_cnt_next = '0;
            end else begin
              state_next = TX_WAIT_WORD;
            end
          end
        end
      end
      TX_DONE: begin
        state_next = TX_IDLE;
      end
      default: begin
        state_next = TX_IDLE;
      end
    endcase
  end

  assign slave_valid = (state_reg == TX_SEND);
  // Gated so the wire stays quiet outside SEND even if residual bits remain.
  assign tx_data     = bit0 & slave_valid;
  assign tx_busy     = (state_reg != TX_IDLE);
  assign tx_done     = (state_reg == TX_DONE);

endmodule

// File: tb/tb_slave_out_tx.sv
// Directed bench for slave_out_tx: single word, burst, stall, source gap,
// grant loss, asynchronous reset, and parity when SLAVE_TX_PARITY_EN is set.
module tb_slave_out_tx;

  localparam int DATA_LEN  = 8;
  localparam int BURST_LEN = 12;
`ifdef SLAVE_TX_PARITY_EN
  localparam int NB = DATA_LEN + 1;
`else
  localparam int NB = DATA_LEN;
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  logic [BURST_LEN-1:0] burst_num;
  logic                 approval_grant;
  logic                 master_ready;
  logic [DATA_LEN-1:0]  word_in;
  logic                 word_valid;
  logic                 word_ack, slave_valid, tx_data, tx_busy, tx_done, tx_abort;

  int total  = 0;
  int passed = 0;

  slave_out_tx #(.DATA_LEN(DATA_LEN), .BURST_LEN(BURST_LEN)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .burst_num      (burst_num),
    .approval_grant (approval_grant),
    .master_ready   (master_ready),
    .word_in        (word_in),
    .word_valid     (word_valid),
    .word_ack       (word_ack),
    .slave_valid    (slave_valid),
    .tx_data        (tx_data),
    .tx_busy        (tx_busy),
    .tx_done        (tx_done),
    .tx_abort       (tx_abort)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  // Expected on-wire frame of a word, LSB first.
  function automatic logic [NB-1:0] frame(input logic [DATA_LEN-1:0] w);
`ifdef SLAVE_TX_PARITY_EN
    return {^w, w};
`else
    return w;
`endif
  endfunction

  // Cycle 0 (start) and cycle 1 (WAIT_WORD, pop if word_valid).
  task automatic do_start(input logic [BURST_LEN-1:0] bn);
    start     = 1'b1;
    burst_num = bn;
    #1;
    chk("start_busy", tx_busy, 0);
    chk("start_ack", word_ack, 0);
    next_cycle;
    start = 1'b0;
    #1;
    chk("wait_busy", tx_busy, 1);
    chk("wait_valid", slave_valid, 0);
    chk("wait_ack", word_ack, word_valid);
    next_cycle;
  endtask

  // Send one word's bit-cycles; optional stall before bit stall_bit.
  task automatic send_bits(input logic [DATA_LEN-1:0] w, input logic exp_ack_last,
                           input int stall_bit, input int stall_len,
                           input logic [DATA_LEN-1:0] next_w, input logic next_valid);
    logic [NB-1:0] f;
    f = frame(w);
    for (int b = 0; b < NB; b++) begin
      if (b == stall_bit) begin
        for (int s = 0; s < stall_len; s++) begin
          master_ready = 1'b0;
          #1;
          chk("stall_valid", slave_valid, 1);
          chk("stall_data", tx_data, f[b]);
          chk("stall_ack", word_ack, 0);
          next_cycle;
        end
        master_ready = 1'b1;
      end
      if (b == NB - 1) begin
        word_in    = next_w;
        word_valid = next_valid;
      end
      #1;
      chk("bit_valid", slave_valid, 1);
      chk("bit_data", tx_data, f[b]);
      chk("bit_ack", word_ack, (b == NB - 1) ? exp_ack_last : 1'b0);
      chk("bit_done", tx_done, 0);
      next_cycle;
    end
  endtask

  task automatic finish_check;
    #1;
    chk("done_pulse", tx_done, 1);
    chk("done_valid", slave_valid, 0);
    chk("done_busy", tx_busy, 1);
    next_cycle;
    #1;
    chk("idle_done", tx_done, 0);
    chk("idle_busy", tx_busy, 0);
    next_cycle;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; burst_num = '0; approval_grant = 1'b1;
    master_ready = 1'b1; word_in = '0; word_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", slave_valid, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_busy", tx_busy, 0);
    chk("rst_done", tx_done, 0);
    chk("rst_abort", tx_abort, 0);
    chk("rst_ack", word_ack, 0);
    reset = 1'b0;
    next_cycle;
    $display("reset: checked idle outputs");

    // Single word A5.
    word_in = 8'hA5; word_valid = 1'b1;
    do_start(0);
    send_bits(8'hA5, 1'b0, -1, 0, 8'hA5, 1'b1);
    finish_check;
    $display("single word A5 sent");

    // Burst of three words back to back.
    word_in = 8'h01;
    do_start(2);
    send_bits(8'h01, 1'b1, -1, 0, 8'hFF, 1'b1);
    send_bits(8'hFF, 1'b1, -1, 0, 8'h3C, 1'b1);
    send_bits(8'h3C, 1'b0, -1, 0, 8'h3C, 1'b1);
    finish_check;
    $display("burst 01 FF 3C sent");

    // Three-cycle stall on bit 4.
    word_in = 8'hA5;
    do_start(0);
    send_bits(8'hA5, 1'b0, 4, 3, 8'hA5, 1'b1);
    finish_check;
    $display("stalled word A5 sent");

    // Source gap between two words.
    word_in = 8'h5A;
    do_start(1);
    send_bits(8'h5A, 1'b0, -1, 0, 8'hC3, 1'b0);
    for (int g = 0; g < 4; g++) begin
      #1;
      chk("gap_busy", tx_busy, 1);
      chk("gap_valid", slave_valid, 0);
      chk("gap_ack", word_ack, 0);
      next_cycle;
    end
    word_valid = 1'b1;
    #1;
    chk("gap_pop", word_ack, 1);
    chk("gap_pop_valid", slave_valid, 0);
    next_cycle;
    send_bits(8'hC3, 1'b0, -1, 0, 8'hC3, 1'b1);
    finish_check;
    $display("gap burst 5A C3 sent");

    // Grant dropped during bit 3.
    word_in = 8'h96;
    do_start(0);
    for (int b = 0; b < 3; b++) begin
      #1;
      chk("pre_abort_data", tx_data, frame(8'h96)[b]);
      next_cycle;
    end
    approval_grant = 1'b0;
    #1;
    chk("abort_pulse", tx_abort, 1);
    chk("abort_valid", slave_valid, 1);
    chk("abort_ack", word_ack, 0);
    next_cycle;
    approval_grant = 1'b1;
    #1;
    chk("post_abort_busy", tx_busy, 0);
    chk("post_abort_valid", slave_valid, 0);
    chk("post_abort_pulse", tx_abort, 0);
    next_cycle;
    #1;
    chk("post_abort_done", tx_done, 0);
    next_cycle;
    $display("grant loss aborted word 96");

    // Asynchronous reset mid-SEND, then a clean transfer.
    word_in = 8'hE7;
    do_start(0);
    for (int b = 0; b < 2; b++) next_cycle;
    #1;
    chk("pre_rst_valid", slave_valid, 1);
    reset = 1'b1;
    #1;
    chk("arst_valid", slave_valid, 0);
    chk("arst_data", tx_data, 0);
    chk("arst_busy", tx_busy, 0);
    chk("arst_done", tx_done, 0);
    chk("arst_abort", tx_abort, 0);
    chk("arst_ack", word_ack, 0);
    next_cycle;
    reset = 1'b0;
    next_cycle;
    word_in = 8'h3C;
    do_start(0);
    send_bits(8'h3C, 1'b0, -1, 0, 8'h3C, 1'b1);
    finish_check;
    $display("reset mid-send recovered, word 3C sent");

`ifdef SLAVE_TX_PARITY_EN
    word_in = 8'h07;
    do_start(0);
    send_bits(8'h07, 1'b0, -1, 0, 8'h07, 1'b1);
    finish_check;
    $display("parity word 07 sent");
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
